parallel_to_serial: RTL and testbench
=====================================

# parallel_to_serial

Converts `width`-bit parallel words into a one-bit-per-cycle serial stream with a `serial_valid` qualifier. It is the transmit-side counterpart of `serial_to_parallel` and sits directly upstream of it. With the default bit order, a word serialized here and deserialized by `serial_to_parallel` is recovered unchanged. The input side uses a valid/ready handshake with a one-word holding buffer, so back-to-back words stream with no idle gap between them.

## Interface
- `width`, default 8: word width in bits; must be ≥ 1.

- `clk`  input  1  clock; all state changes on its rising edge.
- `rst`  input  1  reset, asynchronous, active-low (asserted at 0).
- `parallel_valid`  input  1  upstream has a word on `parallel_data`.
- `parallel_ready`  output  1  block can accept a word this cycle.
- `parallel_data`  input  width  word to serialize.
- `serial_valid`  output  1  `serial_data` carries a valid bit this cycle.
- `serial_data`  output  1  current serial bit.
- `serial_last`  output  1  current bit is the final bit of its word.
- `busy`  output  1  a word is being shifted or is waiting in the buffer.

## Operation
- Storage:
  - shift register `sh[width-1:0]`;
  - bit counter `cnt`, `$clog2(width)+1` bits, counts 0..width-1;
  - holding buffer `buf` plus flag `buf_full`.
- The FSM has two states:
  - IDLE: shifter empty.
  - SHIFT: a word is being emitted.
- Acceptance: a word is accepted in any cycle where `parallel_valid && parallel_ready`.
- `parallel_ready = !buf_full`. It depends on registered state only; there is no combinational path from `parallel_valid`.
- Where an accepted word goes:
  - In IDLE, or in SHIFT on the last-bit cycle with the buffer empty, it loads the shifter directly and the FSM enters or stays in SHIFT with `cnt=0`.
  - In any other SHIFT cycle, it is written to `buf` and `buf_full` is set.
- SHIFT state:
  - `serial_valid=1` every cycle and `serial_data=sh[0]`.
  - Each cycle the shifter shifts right by one and `cnt` increments.
  - `serial_last=1` when `cnt==width-1`.
- End of a word (the `cnt==width-1` cycle):
  - If `buf_full`, the shifter loads `buf`, `buf_full` clears and `cnt` goes to 0. The FSM stays in SHIFT, so there is no gap.
  - Otherwise, if a word is accepted this cycle, it loads as above.
  - Otherwise the FSM goes to IDLE.
- `busy = (state==SHIFT) || buf_full`.
- Bit order is LSB first by default.
- `width==1`: every valid cycle is also a last cycle, and one word can be accepted per cycle.
- The sustained rate is one word per `width` cycles; `parallel_ready` throttles the upstream.

## Timing
- Reset values (asynchronous, immediate on `rst=0`): state IDLE, `cnt=0`, `sh=0`, `buf=0`, `buf_full=0`.
  - Hence `serial_valid=0`, `serial_data=0`, `serial_last=0`, `busy=0`, `parallel_ready=1`.
  - No word is accepted while `rst=0`.
- Latency: a word accepted in cycle N (IDLE) emits bit 0 in cycle N+1 and bit `width-1`, with `serial_last`, in cycle N+width.
- `serial_valid`, `serial_data` and `serial_last` are registered outputs.
- A second word accepted in cycle N+1 fills the buffer, and `parallel_ready` is 0 from cycle N+2 through N+width.
- That buffered word's bit 0 appears in cycle N+width+1, and `parallel_ready` returns to 1 in that same cycle.
- Reset asserted mid-word discards both the shifter contents and the buffer. No partial word is emitted after reset releases.
- Upstream must hold `parallel_data` stable while `parallel_valid && !parallel_ready`. Data is sampled only on the accepting edge.

## Configuration
- `PARALLEL_TO_SERIAL_MSB_FIRST_EN`:
  - Defined: each word is emitted MSB first. `serial_data=sh[width-1]` and the shifter shifts left.
  - Undefined (default): LSB first, compatible with `serial_to_parallel`.
- All timing, handshake and `serial_last` behaviour is identical in both builds.

## Test plan
- Reset, then drive `8'hA5` with valid for one cycle (N):
  - cycles N+1..N+8 show `serial_data` = 1,0,1,0,0,1,0,1 with `serial_valid=1`;
  - `serial_last=1` only at N+8;
  - then `serial_valid=0` and `busy=0`.
- Hold `parallel_valid` high with `8'h01`, `8'h80`, `8'hFF` presented in turn:
  - 24 consecutive `serial_valid` cycles with no gaps;
  - `parallel_ready` is 0 for cycles 2..8 and 10..16 after the first accept;
  - `serial_last` pulses at valid cycles 8, 16 and 24.
- Loopback into `serial_to_parallel` (width 8) with 100 random words at random gaps: every `parallel_valid` pulse out of the deserializer carries the matching word, in order.
- Pull `rst` low after bit 3 of `8'h3C` while `8'hC3` is buffered:
  - outputs go to 0 immediately and `parallel_ready=1`;
  - after release, no further serial bits appear until a new word is sent.
- `width=1`, with words 1,0,1 on consecutive cycles: `serial_data` = 1,0,1 one cycle later, with `serial_valid` and `serial_last` high on all three cycles.
- With `PARALLEL_TO_SERIAL_MSB_FIRST_EN` defined, send `8'hA5`: the bits appear in the order 1,0,1,0,0,1,0,1 (MSB first), with `serial_last` on the 8th bit.

Source files
------------

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: width-bit words in (valid/ready), one bit per cycle out.
// Optional build macro PARALLEL_TO_SERIAL_MSB_FIRST_EN emits MSB first.
module parallel_to_serial #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    output logic             parallel_ready,
    input  logic [width-1:0] parallel_data,
    output logic             serial_valid,
    output logic             serial_data,
    output logic             serial_last,
    output logic             busy
);

    localparam int CW = $clog2(width) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(width - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [width-1:0] r_sh;
    logic [width-1:0] r_hold;
    logic [CW-1:0]    r_cnt;
    logic             r_hold_full;

    logic [width-1:0] w_sh_shift;
    logic             w_bit;
    logic             w_accept;
    logic             w_last;
    logic             w_load_direct;
    logic             w_load_hold;
    logic             w_to_hold;

`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
    assign w_sh_shift = r_sh << 1;
    assign w_bit      = r_sh[width-1];
`else
    assign w_sh_shift = r_sh >> 1;
    assign w_bit      = r_sh[0];
`endif

    // ready only looks at the holding flag, so no valid->ready path exists
    assign w_accept      = parallel_valid && !r_hold_full;
    assign w_last        = (r_state == SHIFT) && (r_cnt == LAST_CNT);
    assign w_load_hold   = w_last && r_hold_full;
    assign w_load_direct = w_accept && ((r_state == IDLE) || w_last);
    assign w_to_hold     = w_accept && (r_state == SHIFT) && !w_last;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: stay in SHIFT while any word is pending
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last && !r_hold_full && !w_accept) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shifter and bit counter; a pending word reloads on the last bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_load_hold) begin
                r_sh <= r_hold;
            end else if (w_load_direct) begin
                r_sh <= parallel_data;
            end else if (r_state == SHIFT) begin
                r_sh <= w_sh_shift;
            end

            if (w_last || w_load_direct) begin
                r_cnt <= '0;
            end else if (r_state == SHIFT) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Holding buffer: fills mid-word, drains into the shifter at word end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_to_hold) begin
                r_hold      <= parallel_data;
                r_hold_full <= 1'b1;
            end else if (w_load_hold) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // Outputs decoded straight from registered state
    always_comb begin
        parallel_ready = !r_hold_full;
        serial_valid   = (r_state == SHIFT);
        serial_data    = (r_state == SHIFT) && w_bit;
        serial_last    = w_last;
        busy           = (r_state == SHIFT) || r_hold_full;
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial: directed and random checks of parallel_to_serial
// against a bit-queue scoreboard, plus a width=1 instance.
module tb_parallel_to_serial;

    localparam int W = 8;
`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    typedef struct packed {
        logic d;
        logic l;
    } sbit_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         pv;
    logic [W-1:0] pd;
    logic         parallel_ready;
    logic         serial_valid;
    logic         serial_data;
    logic         serial_last;
    logic         busy;

    logic         pv1;
    logic [0:0]   pd1;
    logic         ready1;
    logic         sv1;
    logic         sd1;
    logic         sl1;
    logic         busy1;

    sbit_t        q[$];
    logic [W-1:0] wq[$];
    logic [W-1:0] asm_w;
    int           n_assert = 0;
    int           n_fail = 0;

    parallel_to_serial #(.width(W)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .parallel_valid (pv),
        .parallel_ready (parallel_ready),
        .parallel_data  (pd),
        .serial_valid   (serial_valid),
        .serial_data    (serial_data),
        .serial_last    (serial_last),
        .busy           (busy)
    );

    parallel_to_serial #(.width(1)) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .parallel_valid (pv1),
        .parallel_ready (ready1),
        .parallel_data  (pd1),
        .serial_valid   (sv1),
        .serial_data    (sd1),
        .serial_last    (sl1),
        .busy           (busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check8();
        logic ev;
        logic ed;
        logic el;
        logic [W-1:0] w;
        ev = (q.size() > 0);
        ed = ev ? q[0].d : 1'b0;
        el = ev ? q[0].l : 1'b0;
        chk("serial_valid", 32'(serial_valid), 32'(ev));
        chk("serial_data", 32'(serial_data), 32'(ed));
        chk("serial_last", 32'(serial_last), 32'(el));
        chk("parallel_ready", 32'(parallel_ready), 32'(q.size() <= W));
        chk("busy", 32'(busy), 32'(ev));
        if (serial_valid === 1'b1) begin
            if (MSB) asm_w = {asm_w[W-2:0], serial_data};
            else     asm_w = {serial_data, asm_w[W-1:1]};
            if (serial_last === 1'b1) begin
                chk("word_pending", 32'(wq.size() > 0), 32'd1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    chk("loopback_word", 32'(asm_w), 32'(w));
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d,
                        output bit acc);
        sbit_t sb;
        pv = v;
        pd = d;
        check8();
        acc = v && (rst === 1'b1) && (q.size() <= W);
        if (rst !== 1'b1) begin
            q.delete();
            wq.delete();
            asm_w = '0;
        end else begin
            if (q.size() > 0) sb = q.pop_front();
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    sb.d = MSB ? d[W-1-i] : d[i];
                    sb.l = (i == W - 1);
                    q.push_back(sb);
                end
                wq.push_back(d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, '0, a);
    endtask

    initial begin
        bit           acc;
        logic [W-1:0] seq;
        logic [W-1:0] sw [3];
        logic [0:0]   w1 [3];
        int           nv;
        int           nl;
        int           idx;
        int           gap;
        int           tries;
        logic [W-1:0] rw;

        sw = '{8'h01, 8'h80, 8'hFF};
        w1 = '{1'b1, 1'b0, 1'b1};
        rst = 1'b0;
        pv = 1'b0;
        pd = '0;
        pv1 = 1'b0;
        pd1 = '0;
        asm_w = '0;

        #1;
        chk("rst_valid", 32'(serial_valid), 32'd0);
        chk("rst_data", 32'(serial_data), 32'd0);
        chk("rst_last", 32'(serial_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(parallel_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // single word 8'hA5
        step(1'b1, 8'hA5, acc);
        seq = '0;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            if (serial_valid === 1'b1) begin
                seq = {seq[W-2:0], serial_data};
                nv++;
                chk("a5_last_pos", 32'(serial_last), 32'(nv == 8));
            end
            step(1'b0, '0, acc);
        end
        chk("a5_bits", 32'(seq), 32'hA5);
        chk("a5_count", 32'(nv), 32'd8);
        chk("a5_idle_valid", 32'(serial_valid), 32'd0);
        chk("a5_idle_busy", 32'(busy), 32'd0);

        // back-to-back stream 01, 80, FF
        idx = 0;
        nv = 0;
        nl = 0;
        for (int k = 0; k < 28; k++) begin
            chk("stream_ready", 32'(parallel_ready),
                32'(!((k >= 2 && k <= 8) || (k >= 10 && k <= 16))));
            if (serial_valid === 1'b1) begin
                nv++;
                chk("stream_gap", 32'(nv), 32'(k));
                if (serial_last === 1'b1) begin
                    nl++;
                    chk("stream_last_pos", 32'(nv), 32'(8 * nl));
                end
            end
            if (idx < 3) begin
                step(1'b1, sw[idx], acc);
                if (acc) idx++;
            end else begin
                step(1'b0, '0, acc);
            end
        end
        chk("stream_valid_cnt", 32'(nv), 32'd24);
        chk("stream_last_cnt", 32'(nl), 32'd3);

        // reset mid-word with a word buffered
        step(1'b1, 8'h3C, acc);
        step(1'b1, 8'hC3, acc);
        chk("rst_mid_buffered", 32'(parallel_ready), 32'd0);
        idle(3);
        rst = 1'b0;
        q.delete();
        wq.delete();
        asm_w = '0;
        #1;
        chk("rstmid_valid", 32'(serial_valid), 32'd0);
        chk("rstmid_data", 32'(serial_data), 32'd0);
        chk("rstmid_last", 32'(serial_last), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_ready", 32'(parallel_ready), 32'd1);
        step(1'b1, 8'h77, acc);
        rst = 1'b1;
        idle(12);

        // random words with random gaps, checked word-by-word
        for (int n = 0; n < 100; n++) begin
            gap = $urandom_range(0, 3);
            idle(gap);
            rw = W'($urandom);
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 20) begin
                step(1'b1, rw, acc);
                tries++;
            end
        end
        idle(20);
        chk("drain_words_left", 32'(wq.size()), 32'd0);

        // width = 1 instance, one word per cycle
        for (int i = 0; i < 3; i++) begin
            pv1 = 1'b1;
            pd1 = w1[i];
            @(posedge clk);
            #1;
            chk("w1_valid", 32'(sv1), 32'd1);
            chk("w1_data", 32'(sd1), 32'(w1[i]));
            chk("w1_last", 32'(sl1), 32'd1);
            chk("w1_ready", 32'(ready1), 32'd1);
        end
        pv1 = 1'b0;
        @(posedge clk);
        #1;
        chk("w1_idle_valid", 32'(sv1), 32'd0);
        chk("w1_idle_busy", 32'(busy1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
